// File: rtl/fog_pkg.sv
// Shared definitions for the FOG phase-modulation chain: feedback mode
// encoding (common with the step generator) and the driver state type.
package fog_pkg;

   localparam logic [31:0] FB_OFF   = 32'd0;
   localparam logic [31:0] FB_LOOP  = 32'd1;
   localparam logic [31:0] FB_CONST = 32'd2;

   localparam int MIN_HALF_DFLT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN_H = 2'd1,
      RUN_L = 2'd2
   } state_t;

   // Every code outside {LOOP, CONST} means the loop is stopped.
   function automatic logic fb_running(input logic [31:0] fb);
      case (fb)
         FB_LOOP, FB_CONST: return 1'b1;
         FB_OFF:            return 1'b0;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fog_mod_timer.sv
// Bias-modulation timing: half-period counter with period-start latch,
// polarity, end-of-period trigger and its delayed copy.
module fog_mod_timer
   import fog_pkg::*;
#(
   parameter int TRIG_DLY = 2,
   parameter int MIN_HALF = MIN_HALF_DFLT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  state_t      state_i,
   input  logic        run_i,
   input  logic [31:0] mod_half_i,
   output logic        bnd_o,
   output logic        pol_o,
   output logic        trig_o,
   output logic        trig_dly_o
);

   logic [31:0]         cnt_q;
   logic [31:0]         half_q;
   logic [31:0]         half_d;
   logic                pol_q;
   logic                trig_q;
   logic [TRIG_DLY-1:0] dly_q;
   logic                active;

   assign active = (state_i != IDLE) && run_i;
   assign half_d = (mod_half_i < 32'(MIN_HALF)) ? 32'(MIN_HALF) : mod_half_i;
   // A stop request in the boundary cycle suppresses the boundary itself.
   assign bnd_o  = active && (cnt_q == half_q - 32'd1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= '0;
         half_q <= 32'(MIN_HALF);
         pol_q  <= 1'b0;
         trig_q <= 1'b0;
         dly_q  <= '0;
      end else if (!active) begin
         cnt_q  <= '0;
         pol_q  <= 1'b0;
         trig_q <= 1'b0;
         dly_q  <= '0;
      end else begin
         if ((state_i == RUN_H) && (cnt_q == '0)) begin
            half_q <= half_d;
         end
         cnt_q  <= bnd_o ? '0 : cnt_q + 32'd1;
         if (bnd_o) begin
            pol_q <= ~pol_q;
         end
         trig_q <= bnd_o && (state_i == RUN_L);
         dly_q  <= TRIG_DLY'({dly_q, trig_q});
      end
   end

   assign pol_o      = pol_q;
   assign trig_o     = trig_q;
   assign trig_dly_o = dly_q[TRIG_DLY-1];

endmodule

// File: rtl/fog_phase_ramp_gen.sv
// FOG phase-modulator driver: serrodyne ramp integrating the feedback step
// once per half-period, plus square-wave bias, into a registered DAC code.
//
//   state | meaning
//   IDLE  | loop stopped; ramp cleared, DAC held, triggers quiet
//   RUN_H | first half of a modulation period
//   RUN_L | second half; its boundary ends the period and fires o_trig
module fog_phase_ramp_gen
   import fog_pkg::*;
#(
   parameter int DAC_W    = 16,
   parameter int TRIG_DLY = 2,
   parameter int MIN_HALF = MIN_HALF_DFLT
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [31:0]        i_fb_ON,
   input  logic [31:0]        i_mod_half,
   input  logic signed [31:0] i_step,
   input  logic signed [15:0] i_mod_amp_h,
   input  logic signed [15:0] i_mod_amp_l,
   output logic               o_trig,
   output logic               o_trig_dly,
   output logic [DAC_W-1:0]   o_dac,
   output logic               o_dac_valid,
   output logic               o_pol,
   output logic               o_ramp_wrap,
   output logic signed [31:0] o_ramp
);

   state_t             state_q;
   logic [31:0]        fb_q;
   logic [31:0]        ramp_q;
   logic               wrap_q;
   logic [DAC_W-1:0]   dac_q;
   logic               dac_vld_q;
   logic               dac_pend_q;
   logic               run;
   logic               bnd;
   logic               pol;
   logic [32:0]        sum;
   logic               wrap_d;
   logic signed [15:0] amp_sel;
   logic [DAC_W-1:0]   dac_d;

   assign run = fb_running(fb_q);

   fog_mod_timer #(
      .TRIG_DLY (TRIG_DLY),
      .MIN_HALF (MIN_HALF)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .state_i    (state_q),
      .run_i      (run),
      .mod_half_i (i_mod_half),
      .bnd_o      (bnd),
      .pol_o      (pol),
      .trig_o     (o_trig),
      .trig_dly_o (o_trig_dly)
   );

   // Ramp is an unsigned 2pi phase: wrap means crossing 0 in either direction.
   assign sum     = {1'b0, ramp_q} + {1'b0, i_step};
   assign wrap_d  = i_step[31] ? ~sum[32] : sum[32];
   assign amp_sel = pol ? i_mod_amp_h : i_mod_amp_l;
   assign dac_d   = ramp_q[31:32-DAC_W] + DAC_W'(amp_sel);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fb_q       <= '0;
         state_q    <= IDLE;
         ramp_q     <= '0;
         wrap_q     <= 1'b0;
         dac_q      <= '0;
         dac_vld_q  <= 1'b0;
         dac_pend_q <= 1'b0;
      end else begin
         fb_q       <= i_fb_ON;
         wrap_q     <= 1'b0;
         dac_vld_q  <= 1'b0;
         dac_pend_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (run) begin
                  state_q <= RUN_H;
               end
            end
            RUN_H, RUN_L: begin
               if (!run) begin
                  state_q   <= IDLE;
                  ramp_q    <= '0;
                  dac_q     <= '0;
                  dac_vld_q <= 1'b1;
               end else begin
                  if (dac_pend_q) begin
                     dac_q     <= dac_d;
                     dac_vld_q <= 1'b1;
                  end
                  if (bnd) begin
                     ramp_q     <= sum[31:0];
                     wrap_q     <= wrap_d;
                     dac_pend_q <= 1'b1;
                     state_q    <= (state_q == RUN_H) ? RUN_L : RUN_H;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_dac       = dac_q;
   assign o_dac_valid = dac_vld_q;
   assign o_pol       = pol;
   assign o_ramp_wrap = wrap_q;
   assign o_ramp      = ramp_q;

endmodule

// File: tb/tb_fog_phase_ramp_gen.sv
// Bench for fog_phase_ramp_gen: event-time reference model of boundaries,
// triggers, wraps and DAC codes, compared against monitored output events.
module tb_fog_phase_ramp_gen;

   localparam int TRIG_DLY = 2;
   localparam int MINH     = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [31:0]        fb_on = '0;
   logic [31:0]        mod_half = 32'd10;
   logic signed [31:0] step = '0;
   logic signed [15:0] amp_h = '0;
   logic signed [15:0] amp_l = '0;
   logic               o_trig, o_trig_dly, o_dac_valid, o_pol, o_ramp_wrap;
   logic [15:0]        o_dac;
   logic signed [31:0] o_ramp;

   fog_phase_ramp_gen #(.DAC_W(16), .TRIG_DLY(TRIG_DLY), .MIN_HALF(MINH)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_fb_ON     (fb_on),
      .i_mod_half  (mod_half),
      .i_step      (step),
      .i_mod_amp_h (amp_h),
      .i_mod_amp_l (amp_l),
      .o_trig      (o_trig),
      .o_trig_dly  (o_trig_dly),
      .o_dac       (o_dac),
      .o_dac_valid (o_dac_valid),
      .o_pol       (o_pol),
      .o_ramp_wrap (o_ramp_wrap),
      .o_ramp      (o_ramp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   int          mon_vt[$];
   logic [15:0] mon_vv[$];
   int          mon_tr[$];
   int          mon_td[$];
   int          mon_wt[$];
   logic [31:0] mon_wr[$];

   always @(negedge clk) begin
      if (o_dac_valid) begin mon_vt.push_back(cyc); mon_vv.push_back(o_dac); end
      if (o_trig) mon_tr.push_back(cyc);
      if (o_trig_dly) mon_td.push_back(cyc);
      if (o_ramp_wrap) begin mon_wt.push_back(cyc); mon_wr.push_back(o_ramp); end
   end

   task automatic clear_mon();
      mon_vt.delete(); mon_vv.delete(); mon_tr.delete();
      mon_td.delete(); mon_wt.delete(); mon_wr.delete();
   endtask

   logic [31:0] step_tab [0:31];

   // One run from IDLE: start with fbv, stop with offv either well clear of a
   // boundary or exactly in a boundary cycle, then compare every event.
   task automatic run_case(input string nm, input int h1, input int h2, input int nh,
                           input bit drop_bnd, input logic [31:0] fbv, input logic [31:0] offv,
                           input logic [15:0] ah, input logic [15:0] al);
      int          b[0:33];
      int          c0, d, ci, t_end, hc1, hc2;
      logic [31:0] r;
      logic [15:0] dv;
      longint      s;
      int          exp_vt[$];
      logic [15:0] exp_vv[$];
      int          exp_tr[$];
      int          exp_td[$];
      int          exp_wt[$];
      logic [31:0] exp_wr[$];
      hc1 = (h1 < MINH) ? MINH : h1;
      hc2 = (h2 < MINH) ? MINH : h2;
      @(negedge clk);
      mod_half = h1; amp_h = ah; amp_l = al; step = $urandom;
      clear_mon();
      c0 = cyc;
      // b[0]: first RUN_H cycle (one cycle of fb_ON register, one of IDLE exit).
      // b[k]: first cycle after boundary k; periods after the first use h2.
      b[0] = c0 + 2;
      for (int k = 1; k <= nh + 1; k++) b[k] = b[k-1] + ((k <= 2) ? hc1 : hc2);
      d  = drop_bnd ? b[nh+1] - 2 : b[nh] + 2;
      ci = d + 2;
      r  = '0;
      for (int k = 1; k <= nh + 1; k++) begin
         if (b[k] < ci) begin
            s = longint'(r) + longint'($signed(step_tab[k-1]));
            r = r + step_tab[k-1];
            if (s < 0 || s > 64'sd4294967295) begin exp_wt.push_back(b[k]); exp_wr.push_back(r); end
            if (k % 2 == 0) begin
               exp_tr.push_back(b[k]);
               if (b[k] + TRIG_DLY < ci) exp_td.push_back(b[k] + TRIG_DLY);
            end
            if (b[k] + 1 < ci) begin
               dv = r[31:16] + ((k % 2 == 1) ? ah : al);
               exp_vt.push_back(b[k] + 1); exp_vv.push_back(dv);
            end
         end
      end
      exp_vt.push_back(ci); exp_vv.push_back(16'h0000);
      fb_on = fbv;
      t_end = ci + 2 * hc2 + 8;
      while (cyc < t_end) begin
         @(negedge clk);
         if (cyc == d) fb_on = offv;
         if (cyc == b[1] + 1) mod_half = h2;
         for (int k = 1; k <= nh + 1; k++) begin
            if (cyc == b[k-1]) step = $urandom;
            if (cyc == b[k] - 1) step = step_tab[k-1];
         end
      end
      n_total++;
      if (mon_vt.size() != exp_vt.size())
         $display("FAIL %s valid_count got %0d want %0d", nm, mon_vt.size(), exp_vt.size());
      else n_pass++;
      for (int i = 0; i < exp_vt.size() && i < mon_vt.size(); i++) begin
         n_total++;
         if (mon_vt[i] !== exp_vt[i] || mon_vv[i] !== exp_vv[i])
            $display("FAIL %s dac[%0d] got t=%0d v=%h want t=%0d v=%h", nm, i,
                     mon_vt[i] - c0, mon_vv[i], exp_vt[i] - c0, exp_vv[i]);
         else n_pass++;
      end
      n_total++;
      if (mon_tr.size() != exp_tr.size())
         $display("FAIL %s trig_count got %0d want %0d", nm, mon_tr.size(), exp_tr.size());
      else n_pass++;
      for (int i = 0; i < exp_tr.size() && i < mon_tr.size(); i++) begin
         n_total++;
         if (mon_tr[i] !== exp_tr[i])
            $display("FAIL %s trig[%0d] got t=%0d want t=%0d", nm, i, mon_tr[i] - c0, exp_tr[i] - c0);
         else n_pass++;
      end
      n_total++;
      if (mon_td.size() != exp_td.size())
         $display("FAIL %s trig_dly_count got %0d want %0d", nm, mon_td.size(), exp_td.size());
      else n_pass++;
      for (int i = 0; i < exp_td.size() && i < mon_td.size(); i++) begin
         n_total++;
         if (mon_td[i] !== exp_td[i])
            $display("FAIL %s trig_dly[%0d] got t=%0d want t=%0d", nm, i, mon_td[i] - c0, exp_td[i] - c0);
         else n_pass++;
      end
      n_total++;
      if (mon_wt.size() != exp_wt.size())
         $display("FAIL %s wrap_count got %0d want %0d", nm, mon_wt.size(), exp_wt.size());
      else n_pass++;
      for (int i = 0; i < exp_wt.size() && i < mon_wt.size(); i++) begin
         n_total++;
         if (mon_wt[i] !== exp_wt[i] || mon_wr[i] !== exp_wr[i])
            $display("FAIL %s wrap[%0d] got t=%0d ramp=%h want t=%0d ramp=%h", nm, i,
                     mon_wt[i] - c0, mon_wr[i], exp_wt[i] - c0, exp_wr[i]);
         else n_pass++;
      end
      n_total++;
      if ({o_dac, o_ramp, o_pol, o_trig, o_trig_dly} !== '0)
         $display("FAIL %s idle_outputs got dac=%h ramp=%h pol=%b want all 0", nm, o_dac, o_ramp, o_pol);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({o_trig, o_trig_dly, o_dac, o_dac_valid, o_pol, o_ramp_wrap, o_ramp} !== '0)
         $display("FAIL reset_outputs got dac=%h ramp=%h want 0", o_dac, o_ramp);
      else n_pass++;
      rst_n = 1'b1;
      clear_mon();
      repeat (10) @(negedge clk);
      n_total++;
      if (mon_vt.size() + mon_tr.size() + mon_td.size() + mon_wt.size() != 0)
         $display("FAIL reset_release_events got %0d want 0",
                  mon_vt.size() + mon_tr.size() + mon_td.size() + mon_wt.size());
      else n_pass++;
   endtask

   task automatic test_fb_off();
      @(negedge clk);
      fb_on = 32'd3; mod_half = 32'd4; step = 32'h1234_5678; amp_h = 16'h4000; amp_l = 16'hC000;
      clear_mon();
      repeat (40) @(negedge clk);
      n_total++;
      if (mon_vt.size() + mon_tr.size() + mon_td.size() != 0)
         $display("FAIL fb3_events got %0d want 0", mon_vt.size() + mon_tr.size() + mon_td.size());
      else n_pass++;
      n_total++;
      if (o_dac !== 16'h0 || o_ramp !== 32'h0)
         $display("FAIL fb3_outputs got dac=%h ramp=%h want 0", o_dac, o_ramp);
      else n_pass++;
      fb_on = 32'd0;
   endtask

   task automatic test_basic_seq();
      for (int i = 0; i < 32; i++) step_tab[i] = 32'h0100_0000;
      run_case("basic", 10, 10, 6, 1'b0, 32'd1, 32'd0, 16'h4000, 16'hC000);
      n_total++;
      if (mon_vv.size() < 3 || mon_vv[0] !== 16'h4100 || mon_vv[1] !== 16'hC200 || mon_vv[2] !== 16'h4300)
         $display("FAIL basic_dac_literal got %h %h %h want 4100 c200 4300", mon_vv[0], mon_vv[1], mon_vv[2]);
      else n_pass++;
      n_total++;
      if (mon_vt.size() < 2 || mon_vt[1] - mon_vt[0] != 10)
         $display("FAIL basic_valid_spacing got %0d want 10", mon_vt[1] - mon_vt[0]);
      else n_pass++;
      n_total++;
      if (mon_tr.size() < 2 || mon_tr[1] - mon_tr[0] != 20)
         $display("FAIL basic_trig_spacing got %0d want 20", mon_tr[1] - mon_tr[0]);
      else n_pass++;
      n_total++;
      if (mon_td.size() < 1 || mon_tr.size() < 1 || mon_td[0] - mon_tr[0] != 2)
         $display("FAIL basic_trig_dly_offset got %0d want 2", mon_td[0] - mon_tr[0]);
      else n_pass++;
   endtask

   task automatic test_wrap();
      step_tab[0] = 32'h7800_0000; step_tab[1] = 32'h7800_0000;
      step_tab[2] = 32'h2000_0000; step_tab[3] = 32'hE000_0000;
      run_case("wrap", 6, 6, 4, 1'b0, 32'd2, 32'd0, 16'h0000, 16'h0000);
      n_total++;
      if (mon_wr.size() != 2 || mon_wr[0] !== 32'h1000_0000 || mon_wr[1] !== 32'hF000_0000)
         $display("FAIL wrap_literal got n=%0d %h %h want 10000000 f0000000", mon_wr.size(), mon_wr[0], mon_wr[1]);
      else n_pass++;
   endtask

   task automatic test_half();
      for (int i = 0; i < 32; i++) step_tab[i] = $urandom;
      run_case("half_clamp", 2, 2, 5, 1'b0, 32'd1, 32'd0, 16'h1111, 16'hEEEE);
      n_total++;
      if (mon_vt.size() < 2 || mon_vt[1] - mon_vt[0] != MINH)
         $display("FAIL half_clamp_spacing got %0d want %0d", mon_vt[1] - mon_vt[0], MINH);
      else n_pass++;
      run_case("half_change", 10, 16, 6, 1'b0, 32'd1, 32'd0, 16'h2000, 16'hE000);
      n_total++;
      if (mon_tr.size() < 2 || mon_tr[1] - mon_tr[0] != 32)
         $display("FAIL half_change_period got %0d want 32", mon_tr[1] - mon_tr[0]);
      else n_pass++;
   endtask

   task automatic test_drop_on_boundary();
      for (int i = 0; i < 32; i++) step_tab[i] = $urandom;
      run_case("drop_bnd", 7, 7, 3, 1'b1, 32'd1, 32'd0, 16'h0400, 16'hFC00);
      run_case("resume", 7, 7, 2, 1'b0, 32'd1, 32'd0, 16'h0400, 16'hFC00);
   endtask

   task automatic test_reset_mid();
      bit found;
      int nv, nt;
      @(negedge clk);
      mod_half = 32'd10; step = 32'h0100_0000; amp_h = 16'h4000; amp_l = 16'hC000; fb_on = 32'd1;
      clear_mon();
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (o_trig) found = 1'b1;
      end
      n_total++;
      if (!found) $display("FAIL rst_mid_trig_seen got 0 want 1");
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({o_trig, o_trig_dly, o_dac, o_dac_valid, o_pol, o_ramp_wrap, o_ramp} !== '0)
         $display("FAIL rst_mid_outputs got dac=%h ramp=%h want 0", o_dac, o_ramp);
      else n_pass++;
      fb_on = 32'd0;
      repeat (3) @(negedge clk);
      nv = mon_vt.size(); nt = mon_tr.size();
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      n_total++;
      if (mon_td.size() != 0) $display("FAIL rst_mid_trig_dly got %0d want 0", mon_td.size());
      else n_pass++;
      n_total++;
      if (mon_vt.size() != nv || mon_tr.size() != nt)
         $display("FAIL rst_mid_release_events got %0d want 0", mon_vt.size() - nv + mon_tr.size() - nt);
      else n_pass++;
      n_total++;
      if (o_dac !== 16'h0 || o_ramp !== 32'h0 || o_pol !== 1'b0)
         $display("FAIL rst_mid_idle got dac=%h ramp=%h want 0", o_dac, o_ramp);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 32; i++) step_tab[i] = $urandom;
         run_case("random", $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(1, 7),
                  1'($urandom_range(0, 1)), 32'($urandom_range(1, 2)),
                  ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd3 + 32'($urandom_range(0, 100)),
                  16'($urandom), 16'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_fb_off();
      test_basic_seq();
      test_wrap();
      test_half();
      test_drop_on_boundary();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
